// File: rtl/bitmap_sprite_pkg.sv
// Shared types and helpers for the bitmap sprite renderer: RGB struct,
// reset-time grey palette ramp and scaled sprite box dimensions.
package bitmap_sprite_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Entry k of an evenly spaced grey ramp from black to white.
  function automatic rgb_t grey_ramp(input int k, input int bpp);
    int v;
    v = (k * 255) / ((1 << bpp) - 1);
    grey_ramp = '{r: 8'(v), g: 8'(v), b: 8'(v)};
  endfunction

  function automatic int BOX_W(input int bmp_w, input int scale_log2);
    return bmp_w << scale_log2;
  endfunction

  function automatic int BOX_H(input int bmp_h, input int scale_log2);
    return bmp_h << scale_log2;
  endfunction

endpackage

// File: rtl/bitmap_sprite_ram.sv
// Simple dual-port texel RAM: one write port, one registered read port.
// A read colliding with a write to the same address returns the old data.
module bitmap_sprite_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/bitmap_sprite_renderer.sv
// Two-stage renderer for one palettised, power-of-two scaled bitmap sprite.
// Optional build macro BITMAP_MIRROR_EN adds latched horizontal/vertical flip.
module bitmap_sprite_renderer
  import bitmap_sprite_pkg::*;
#(
  parameter int          H_BITS     = 10,
  parameter int          V_BITS     = 10,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          BMP_W      = 16,
  parameter int          BMP_H      = 16,
  parameter int          BPP        = 2,
  parameter int          SCALE_LOG2 = 2,
  parameter logic [23:0] BG_RGB     = 24'h000040
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [H_BITS-1:0]                   i_hpos,
  input  logic [V_BITS-1:0]                   i_vpos,
  input  logic                                i_visible,
  input  logic [H_BITS-1:0]                   i_x,
  input  logic [V_BITS-1:0]                   i_y,
  input  logic                                i_bmp_we,
  input  logic [$clog2(BMP_W*BMP_H)-1:0]      i_bmp_addr,
  input  logic [BPP-1:0]                      i_bmp_data,
  input  logic                                i_pal_we,
  input  logic [BPP-1:0]                      i_pal_addr,
  input  logic [23:0]                         i_pal_data,
`ifdef BITMAP_MIRROR_EN
  input  logic                                i_hflip,
  input  logic                                i_vflip,
`endif
  output logic [H_BITS-1:0]                   o_hpos,
  output logic [V_BITS-1:0]                   o_vpos,
  output logic                                o_visible,
  output logic [7:0]                          o_r,
  output logic [7:0]                          o_g,
  output logic [7:0]                          o_b
);

  localparam int NPAL = 1 << BPP;
  localparam int CW   = $clog2(BMP_W);
  localparam int RW   = $clog2(BMP_H);
  localparam logic [V_BITS-1:0] V_LATCH  = V_BITS'(V_ACTIVE);
  localparam logic [H_BITS:0]   H_END    = (H_BITS+1)'(H_ACTIVE);
  localparam logic [H_BITS:0]   BOX_W_L  = (H_BITS+1)'(BOX_W(BMP_W, SCALE_LOG2));
  localparam logic [V_BITS:0]   BOX_H_L  = (V_BITS+1)'(BOX_H(BMP_H, SCALE_LOG2));

  logic [H_BITS-1:0] pos_x;
  logic [V_BITS-1:0] pos_y;
  logic              latch;
`ifdef BITMAP_MIRROR_EN
  logic              hflip;
  logic              vflip;
`endif
  rgb_t              pal [NPAL];

  logic [H_BITS-1:0] dx;
  logic [V_BITS-1:0] dy;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic              inbox;

  logic [BPP-1:0]    idx_p1;
  logic              inbox_p1, vis_p1;
  logic [H_BITS-1:0] hpos_p1;
  logic [V_BITS-1:0] vpos_p1;

  rgb_t              rgb_next;
  rgb_t              rgb_p2;
  logic              vis_p2;
  logic [H_BITS-1:0] hpos_p2;
  logic [V_BITS-1:0] vpos_p2;

  // Position (and flips) are shadowed once per frame so a mid-frame move never tears.
  assign latch = (i_vpos == V_LATCH) && (i_hpos == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pos_x <= '0;
      pos_y <= '0;
`ifdef BITMAP_MIRROR_EN
      hflip <= 1'b0;
      vflip <= 1'b0;
`endif
    end else if (latch) begin
      pos_x <= i_x;
      pos_y <= i_y;
`ifdef BITMAP_MIRROR_EN
      hflip <= i_hflip;
      vflip <= i_vflip;
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NPAL; k++) pal[k] <= grey_ramp(k, BPP);
    end else if (i_pal_we) begin
      pal[i_pal_addr] <= i_pal_data;
    end
  end

  // Stage 1: box test and texel address; pixels left/above the sprite wrap to large offsets.
  always_comb begin
    dx  = i_hpos - pos_x;
    dy  = i_vpos - pos_y;
    col = dx[SCALE_LOG2 +: CW];
    row = dy[SCALE_LOG2 +: RW];
`ifdef BITMAP_MIRROR_EN
    col = col ^ {CW{hflip}};
    row = row ^ {RW{vflip}};
`endif
    inbox = ({1'b0, dx} < BOX_W_L) && ({1'b0, dy} < BOX_H_L) && ({1'b0, i_hpos} < H_END);
  end

  bitmap_sprite_ram #(
    .DEPTH (BMP_W * BMP_H),
    .WIDTH (BPP),
    .AW    (CW + RW)
  ) u_ram (
    .clk   (i_clk),
    .we    (i_bmp_we),
    .waddr (i_bmp_addr),
    .wdata (i_bmp_data),
    .raddr ({row, col}),
    .rdata (idx_p1)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      inbox_p1 <= 1'b0;
      vis_p1   <= 1'b0;
      hpos_p1  <= '0;
      vpos_p1  <= '0;
    end else begin
      inbox_p1 <= inbox;
      vis_p1   <= i_visible;
      hpos_p1  <= i_hpos;
      vpos_p1  <= i_vpos;
    end
  end

  // Stage 2: palette lookup; index 0 is transparent and shows the background.
  always_comb begin
    rgb_next = '0;
    if (vis_p1) begin
      if (!inbox_p1 || idx_p1 == '0) rgb_next = BG_RGB;
      else                           rgb_next = pal[idx_p1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rgb_p2  <= '0;
      vis_p2  <= 1'b0;
      hpos_p2 <= '0;
      vpos_p2 <= '0;
    end else begin
      rgb_p2  <= rgb_next;
      vis_p2  <= vis_p1;
      hpos_p2 <= hpos_p1;
      vpos_p2 <= vpos_p1;
    end
  end

  assign o_hpos    = hpos_p2;
  assign o_vpos    = vpos_p2;
  assign o_visible = vis_p2;
  assign o_r       = rgb_p2.r;
  assign o_g       = rgb_p2.g;
  assign o_b       = rgb_p2.b;

endmodule

// File: tb/tb_bitmap_sprite_renderer.sv
// Randomised self-checking bench for bitmap_sprite_renderer with a pixel-level reference model.
module tb_bitmap_sprite_renderer;

  localparam logic [23:0] BG  = 24'h000040;
  localparam logic [23:0] RED = 24'hFF0000;
  localparam logic [23:0] GRN = 24'h00FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hpos = '0, vpos = '0, x_in = '0, y_in = '0;
  logic        visible = 1'b0;
  logic        bmp_we = 1'b0, pal_we = 1'b0;
  logic [7:0]  bmp_addr = '0;
  logic [1:0]  bmp_data = '0, pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic        hflip = 1'b0, vflip = 1'b0;
  logic [9:0]  o_hpos, o_vpos;
  logic        o_visible;
  logic [7:0]  o_r, o_g, o_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bitmap_sprite_renderer dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_hpos     (hpos),
    .i_vpos     (vpos),
    .i_visible  (visible),
    .i_x        (x_in),
    .i_y        (y_in),
    .i_bmp_we   (bmp_we),
    .i_bmp_addr (bmp_addr),
    .i_bmp_data (bmp_data),
    .i_pal_we   (pal_we),
    .i_pal_addr (pal_addr),
    .i_pal_data (pal_data),
`ifdef BITMAP_MIRROR_EN
    .i_hflip    (hflip),
    .i_vflip    (vflip),
`endif
    .o_hpos     (o_hpos),
    .o_vpos     (o_vpos),
    .o_visible  (o_visible),
    .o_r        (o_r),
    .o_g        (o_g),
    .o_b        (o_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what each screen pixel must look like, from position, bitmap and palette.
  logic [1:0]  m_bmp [256];
  logic [23:0] m_pal [4];
  int          m_px, m_py;
  bit          m_hf, m_vf;
  bit          s1_vis, s1_in;
  logic [1:0]  s1_idx;
  int          s1_h, s1_v;
  bit          e_vis;
  int          e_h, e_v;
  logic [23:0] e_rgb;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) m_pal[k] = 24'(k * 85) * 24'h010101;
      m_px = 0; m_py = 0; m_hf = 0; m_vf = 0;
      s1_vis = 0; s1_in = 0; s1_idx = 0; s1_h = 0; s1_v = 0;
      e_vis = 0; e_h = 0; e_v = 0; e_rgb = 0;
    end else begin
      int c, r;
      e_vis = s1_vis; e_h = s1_h; e_v = s1_v;
      if (!s1_vis)                       e_rgb = 24'h0;
      else if (!s1_in || s1_idx == 2'd0) e_rgb = BG;
      else                               e_rgb = m_pal[s1_idx];
      s1_vis = visible; s1_h = int'(hpos); s1_v = int'(vpos);
      s1_in  = (s1_h >= m_px) && (s1_h < m_px + 64) && (s1_h < 640) &&
               (s1_v >= m_py) && (s1_v < m_py + 64);
      s1_idx = 2'd0;
      if (s1_in) begin
        c = (s1_h - m_px) / 4;
        r = (s1_v - m_py) / 4;
        if (m_hf) c = 15 - c;
        if (m_vf) r = 15 - r;
        s1_idx = m_bmp[r * 16 + c];
      end
      if (bmp_we) m_bmp[bmp_addr] = bmp_data;
      if (pal_we) m_pal[pal_addr] = pal_data;
      if (vpos == 10'd480 && hpos == 10'd0) begin
        m_px = int'(x_in); m_py = int'(y_in);
`ifdef BITMAP_MIRROR_EN
        m_hf = hflip; m_vf = vflip;
`endif
      end
    end
    #1;
    check("rgb", {40'h0, o_r, o_g, o_b}, {40'h0, e_rgb});
    check("pos", {43'h0, o_visible, o_hpos, o_vpos}, {43'h0, e_vis, 10'(e_h), 10'(e_v)});
  end

  function automatic logic [1:0] checker_idx(input int a);
    return ((((a / 16) / 4) + ((a % 16) / 4)) % 2 == 1) ? 2'd2 : 2'd1;
  endfunction

  task automatic wr_bmp(input int a, input logic [1:0] d);
    @(negedge clk); bmp_we = 1; bmp_addr = 8'(a); bmp_data = d;
    @(negedge clk); bmp_we = 0;
  endtask

  task automatic wr_pal(input int a, input logic [23:0] d);
    @(negedge clk); pal_we = 1; pal_addr = 2'(a); pal_data = d;
    @(negedge clk); pal_we = 0;
  endtask

  task automatic latch(input int x, input int y);
    @(negedge clk); x_in = 10'(x); y_in = 10'(y); vpos = 10'd480; hpos = 10'd0; visible = 0;
    @(negedge clk); hpos = 10'd1;
  endtask

  // Drive one pixel and check the colour that emerges two clocks later.
  task automatic probe(input string name, input int h, input int v, input bit vis,
                       input logic [23:0] exp);
    @(negedge clk); hpos = 10'(h); vpos = 10'(v); visible = vis;
    @(posedge clk);
    @(negedge clk); bmp_we = 0; pal_we = 0;
    @(posedge clk); #2;
    check(name, {40'h0, o_r, o_g, o_b}, {40'h0, exp});
    check({name, "_h"}, {54'h0, o_hpos}, {54'h0, 10'(h)});
    visible = 0;
  endtask

  initial begin
    int bx, by;
    repeat (4) @(posedge clk);
    #2;
    check("rst_rgb", {40'h0, o_r, o_g, o_b}, 64'h0);
    check("rst_vis", {63'h0, o_visible}, 64'h0);
    @(negedge clk); rst = 0;

    // Reset palette is a grey ramp.
    wr_bmp(0, 2'd3);
    probe("pal3_white", 0, 0, 1, 24'hFFFFFF);
    wr_bmp(0, 2'd1);
    probe("pal1_grey", 0, 0, 1, 24'h555555);

    for (int a = 0; a < 256; a++) wr_bmp(a, checker_idx(a));
    wr_pal(1, RED);
    wr_pal(2, GRN);
    latch(100, 50);
    probe("chk_100", 100, 50, 1, RED);
    probe("chk_116", 116, 50, 1, GRN);
    probe("chk_99", 99, 50, 1, BG);

    // A new request mid-frame waits for the next latch.
    @(negedge clk); x_in = 10'd200;
    probe("shadow_old", 100, 50, 1, RED);
    probe("shadow_new_early", 200, 50, 1, BG);
    latch(200, 50);
    probe("shadow_new", 200, 50, 1, RED);
    probe("shadow_old_gone", 100, 50, 1, BG);

    latch(630, 50);
    probe("clip_630", 630, 50, 1, RED);
    probe("clip_639", 639, 50, 1, RED);
    probe("nowrap_0", 0, 50, 1, BG);
    probe("nowrap_53", 53, 50, 1, BG);

    latch(100, 50);
    wr_bmp(0, 2'd0);
    probe("idx0_bg", 100, 50, 1, BG);
    probe("invisible", 100, 50, 0, 24'h0);
    bmp_we = 1; bmp_addr = 8'd0; bmp_data = 2'd2;
    probe("collide_old", 100, 50, 1, BG);
    probe("collide_new", 100, 50, 1, GRN);
    wr_bmp(0, 2'd1);

    hflip = 1;
    latch(100, 50);
`ifdef BITMAP_MIRROR_EN
    probe("mirror_col15", 100, 50, 1, GRN);
`else
    probe("mirror_col0", 100, 50, 1, RED);
`endif
    hflip = 0;

    // Randomised frames around the sprite, with writes and a reset pulse mixed in.
    for (int f = 0; f < 6; f++) begin
      bx = $urandom_range(560, 0);
      by = $urandom_range(400, 0);
`ifdef BITMAP_MIRROR_EN
      hflip = 1'($urandom); vflip = 1'($urandom);
`endif
      latch(bx, by);
      if (f == 3) begin
        @(negedge clk); rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        bx = 0; by = 0;
      end
      for (int i = 0; i < 400; i++) begin
        int h, v;
        h = bx - 4 + int'($urandom_range(72, 0));
        v = by - 4 + int'($urandom_range(72, 0));
        if (h < 0) h = 0;
        if (h > 639) h = 639;
        if (v < 0) v = 0;
        @(negedge clk);
        hpos = 10'(h); vpos = 10'(v);
        visible = ($urandom_range(7, 0) != 0);
        bmp_we = ($urandom_range(5, 0) == 0);
        bmp_addr = 8'($urandom); bmp_data = 2'($urandom);
        pal_we = ($urandom_range(9, 0) == 0);
        pal_addr = 2'($urandom); pal_data = 24'($urandom);
        if ($urandom_range(50, 0) == 0) x_in = 10'($urandom_range(560, 0));
      end
      @(negedge clk); bmp_we = 0; pal_we = 0; visible = 0;
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
